can_error_frame_ctrl: RTL and testbench

- Sequences the CAN error frame after the bit-level error detector blocks (bit, stuff, form, ACK, CRC, EOF) flag a fault.
- Collects their active-low error indications, latches a priority-encoded error code, drives the error flag, delimiter and intermission onto TX, and holds the detector blocks in reset until the bus is clean.
- Sits between the error block bank and the TX mux, clocked on the sample point.

---
 rtl/can_err_pkg.sv | 46 ++++
 rtl/can_fault_conf_cnt.sv | 60 ++++++
 rtl/can_error_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_can_error_frame_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/can_err_pkg.sv
// can_err_pkg: shared types and constants for the CAN error frame
// controller and its optional fault confinement counters.
package can_err_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLAG,
    ST_WAIT_REC,
    ST_DELIM,
    ST_IFS
  } state_t;

  localparam logic [2:0] EC_NONE  = 3'd0;
  localparam logic [2:0] EC_BIT   = 3'd1;
  localparam logic [2:0] EC_STUFF = 3'd2;
  localparam logic [2:0] EC_FORM  = 3'd3;
  localparam logic [2:0] EC_ACK   = 3'd4;
  localparam logic [2:0] EC_CRC   = 3'd5;
  localparam logic [2:0] EC_EOF   = 3'd6;

  localparam int FLAG_LEN_DEF  = 6;
  localparam int DELIM_LEN_DEF = 8;
  localparam int IFS_LEN_DEF   = 3;
  localparam int DOM_STEP_DEF  = 8;

  localparam logic [8:0] TEC_MAX  = 9'd511;
  localparam logic [8:0] TEC_STEP = 9'd8;
  localparam logic [8:0] TEC_PAS  = 9'd127;
  localparam logic [8:0] TEC_OFF  = 9'd255;
  localparam logic [7:0] REC_MAX  = 8'd255;
  localparam logic [7:0] REC_PAS  = 8'd127;

  // err_n = {bit, stuff, form, ack, crc, eof}, active-low
  function automatic logic [2:0] err_prio(input logic [5:0] err_n);
    logic [2:0] code;
    code = EC_NONE;
    if (!err_n[5])      code = EC_BIT;
    else if (!err_n[4]) code = EC_STUFF;
    else if (!err_n[3]) code = EC_FORM;
    else if (!err_n[2]) code = EC_ACK;
    else if (!err_n[1]) code = EC_CRC;
    else if (!err_n[0]) code = EC_EOF;
    return code;
  endfunction

endpackage

// File: rtl/can_fault_conf_cnt.sv
// can_fault_conf_cnt: transmit/receive error counters with derived
// error-passive and bus-off status.
module can_fault_conf_cnt
  import can_err_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       transmitter,
  input  logic       enter_flag,
  input  logic       restart,
  input  logic       dom_overrun,
  input  logic       frame_done,
  output logic [8:0] tec,
  output logic [7:0] rec,
  output logic       passive,
  output logic       bus_off
);

  logic       restarted;
  logic       bump;
  logic       drop;
  logic [8:0] tec_n;
  logic [7:0] rec_n;

  assign bump = enter_flag | dom_overrun;
  assign drop = frame_done & ~restarted;

  // decrement first so a new flag in the same cycle still lands on top
  always_comb begin
    tec_n = tec;
    rec_n = rec;
    if (drop) begin
      if (transmitter) tec_n = (tec == '0) ? '0 : tec - 9'd1;
      else             rec_n = (rec == '0) ? '0 : rec - 8'd1;
    end
    if (bump) begin
      if (transmitter)
        tec_n = (tec_n > TEC_MAX - TEC_STEP) ? TEC_MAX : tec_n + TEC_STEP;
      else
        rec_n = (rec_n == REC_MAX) ? REC_MAX : rec_n + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tec       <= '0;
      rec       <= '0;
      restarted <= 1'b0;
    end else begin
      tec <= tec_n;
      rec <= rec_n;
      if (restart)         restarted <= 1'b1;
      else if (frame_done) restarted <= 1'b0;
    end
  end

  assign passive = (tec > TEC_PAS) || (rec > REC_PAS);
  assign bus_off = (tec > TEC_OFF);

endmodule

// File: rtl/can_error_frame_ctrl.sv
// can_error_frame_ctrl: CAN error frame sequencer (flag, delimiter, IFS).
// Define CAN_FAULT_CONF_EN to add TEC/REC fault confinement counters.
module can_error_frame_ctrl
  import can_err_pkg::*;
#(
  parameter int FLAG_LEN  = FLAG_LEN_DEF,
  parameter int DELIM_LEN = DELIM_LEN_DEF,
  parameter int IFS_LEN   = IFS_LEN_DEF,
  parameter int DOM_STEP  = DOM_STEP_DEF
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       Bit_Error,
  input  logic       Stuff_Error,
  input  logic       Form_Error,
  input  logic       Ack_Error,
  input  logic       CRC_Error,
  input  logic       EOF_Error,
`ifdef CAN_FAULT_CONF_EN
  input  logic       Transmitter,
  output logic [8:0] TEC,
  output logic [7:0] REC,
  output logic       Bus_Off,
`else
  input  logic       Error_Passive,
`endif
  output logic       TX,
  output logic [2:0] Error_Code,
  output logic       Error_Block_Reset,
  output logic       Err_Frame_Busy,
  output logic       Dom_Overrun,
  output logic       Frame_Done
);

  localparam logic [3:0] FLAG_LAST  = 4'(FLAG_LEN - 1);
  localparam logic [3:0] DELIM_LAST = 4'(DELIM_LEN - 1);
  localparam logic [3:0] IFS_LAST   = 4'(IFS_LEN - 1);
  localparam logic [3:0] DOM_LAST   = 4'(DOM_STEP - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] dcnt;
  logic [5:0] err_n;
  logic       err_any;
  logic       off;

  assign err_n   = {Bit_Error, Stuff_Error, Form_Error,
                    Ack_Error, CRC_Error, EOF_Error};
  assign err_any = ~&err_n;

`ifdef CAN_FAULT_CONF_EN
  logic Error_Passive;
  logic restart;
  logic enter_flag;

  assign restart    = (state == ST_DELIM) && !RX;
  assign enter_flag = restart ||
                      ((state == ST_IDLE) && err_any && !Bus_Off);
  assign off        = Bus_Off;

  can_fault_conf_cnt u_cnt (
    .clk         (SP),
    .reset       (reset),
    .transmitter (Transmitter),
    .enter_flag  (enter_flag),
    .restart     (restart),
    .dom_overrun (Dom_Overrun),
    .frame_done  (Frame_Done),
    .tec         (TEC),
    .rec         (REC),
    .passive     (Error_Passive),
    .bus_off     (Bus_Off)
  );
`else
  assign off = 1'b0;
`endif

  always_ff @(posedge SP) begin
    if (!reset) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      dcnt              <= '0;
      TX                <= 1'b1;
      Error_Code        <= EC_NONE;
      Error_Block_Reset <= 1'b0;
      Err_Frame_Busy    <= 1'b0;
      Dom_Overrun       <= 1'b0;
      Frame_Done        <= 1'b0;
    end else begin
      Dom_Overrun <= 1'b0;
      Frame_Done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          TX <= 1'b1;
          if (err_any && !off) begin
            state             <= ST_FLAG;
            cnt               <= '0;
            Error_Block_Reset <= 1'b1;
            Err_Frame_Busy    <= 1'b1;
            Error_Code        <= err_prio(err_n);
            TX                <= Error_Passive;
          end
        end
        ST_FLAG: begin
          if (cnt == FLAG_LAST) begin
            state <= ST_WAIT_REC;
            TX    <= 1'b1;
            dcnt  <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_WAIT_REC: begin
          if (RX) begin
            state <= ST_DELIM;
            cnt   <= 4'd1;
          end else if (dcnt == DOM_LAST) begin
            Dom_Overrun <= 1'b1;
            dcnt        <= '0;
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        ST_DELIM: begin
          if (!RX) begin
            state      <= ST_FLAG;
            cnt        <= '0;
            Error_Code <= EC_FORM;
            TX         <= Error_Passive;
          end else if (cnt == DELIM_LAST) begin
            state <= ST_IFS;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_IFS: begin
          if (!RX || cnt == IFS_LAST) begin
            state             <= ST_IDLE;
            Frame_Done        <= 1'b1;
            Error_Block_Reset <= 1'b0;
            Err_Frame_Busy    <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef CAN_FAULT_CONF_EN
      // bus-off parks the node recessive until an external reset
      if (Bus_Off) begin
        state             <= ST_IDLE;
        TX                <= 1'b1;
        Error_Block_Reset <= 1'b0;
        Err_Frame_Busy    <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_can_error_frame_ctrl.sv
// tb_can_error_frame_ctrl: randomized error-frame scenarios checked
// against a bit-timeline model of the error frame.
module tb_can_error_frame_ctrl;

  localparam int FL = 6;
  localparam int DL = 8;
  localparam int IL = 3;
  localparam int DS = 8;

  logic       SP = 1'b0;
  logic       reset = 1'b0;
  logic       RX = 1'b1;
  logic       Bit_Error = 1'b1;
  logic       Stuff_Error = 1'b1;
  logic       Form_Error = 1'b1;
  logic       Ack_Error = 1'b1;
  logic       CRC_Error = 1'b1;
  logic       EOF_Error = 1'b1;
  logic       Error_Passive = 1'b0;
  logic       TX;
  logic [2:0] Error_Code;
  logic       Error_Block_Reset;
  logic       Err_Frame_Busy;
  logic       Dom_Overrun;
  logic       Frame_Done;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] m_code = 3'd0;

  can_error_frame_ctrl #(
    .FLAG_LEN  (FL),
    .DELIM_LEN (DL),
    .IFS_LEN   (IL),
    .DOM_STEP  (DS)
  ) dut (
    .SP                (SP),
    .reset             (reset),
    .RX                (RX),
    .Bit_Error         (Bit_Error),
    .Stuff_Error       (Stuff_Error),
    .Form_Error        (Form_Error),
    .Ack_Error         (Ack_Error),
    .CRC_Error         (CRC_Error),
    .EOF_Error         (EOF_Error),
    .Error_Passive     (Error_Passive),
    .TX                (TX),
    .Error_Code        (Error_Code),
    .Error_Block_Reset (Error_Block_Reset),
    .Err_Frame_Busy    (Err_Frame_Busy),
    .Dom_Overrun       (Dom_Overrun),
    .Frame_Done        (Frame_Done)
  );

  always #5 SP = ~SP;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  // cause = position of first active-low input in priority order
  function automatic logic [2:0] cause(input logic [5:0] en);
    for (int i = 5; i >= 0; i--)
      if (!en[i]) return 3'(6 - i);
    return 3'd0;
  endfunction

  function automatic logic [5:0] rnd_err();
    return 6'($urandom);
  endfunction

  task automatic step(input logic rx, input logic [5:0] en,
                      input logic pas, input logic rst,
                      input logic etx, input logic eebr,
                      input logic ebusy, input logic edom,
                      input logic edone);
    @(negedge SP);
    RX = rx;
    {Bit_Error, Stuff_Error, Form_Error,
     Ack_Error, CRC_Error, EOF_Error} = en;
    Error_Passive = pas;
    reset = rst;
    @(posedge SP);
    #1;
    check("tx", 8'(TX), 8'(etx));
    check("code", 8'(Error_Code), 8'(m_code));
    check("blk_rst", 8'(Error_Block_Reset), 8'(eebr));
    check("busy", 8'(Err_Frame_Busy), 8'(ebusy));
    check("dom_ovr", 8'(Dom_Overrun), 8'(edom));
    check("done", 8'(Frame_Done), 8'(edone));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 6'h3f, 1'($urandom), 1'b1, 1'b1, 1'b0, 1'b0,
           1'b0, 1'b0);
  endtask

  // nd: dominant bits after flag; derr: delimiter bit (2..DL) driven
  // dominant once; idom: IFS bit (1..IL) driven dominant
  task automatic run_frame(input logic [5:0] en, input logic pas,
                           input int nd, input int derr,
                           input int idom);
    logic p;
    logic again;
    logic last;
    int   de;
    p = pas;
    de = derr;
    m_code = cause(en);
    step(1'b1, en, pas, 1'b1, pas, 1'b1, 1'b1, 1'b0, 1'b0);
    again = 1'b1;
    while (again) begin
      again = 1'b0;
      for (int i = 1; i < FL; i++)
        step(1'($urandom), rnd_err(), 1'($urandom), 1'b1, p,
             1'b1, 1'b1, 1'b0, 1'b0);
      step(1'($urandom), rnd_err(), 1'($urandom), 1'b1, 1'b1,
           1'b1, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= nd; k++)
        step(1'b0, rnd_err(), 1'($urandom), 1'b1, 1'b1, 1'b1, 1'b1,
             (k % DS) == 0, 1'b0);
      step(1'b1, rnd_err(), 1'($urandom), 1'b1, 1'b1, 1'b1, 1'b1,
           1'b0, 1'b0);
      for (int b = 2; b <= DL; b++) begin
        if (b == de) begin
          p = 1'($urandom);
          m_code = 3'd3;
          step(1'b0, rnd_err(), p, 1'b1, p, 1'b1, 1'b1, 1'b0, 1'b0);
          again = 1'b1;
          de = 0;
          break;
        end
        step(1'b1, rnd_err(), 1'($urandom), 1'b1, 1'b1, 1'b1, 1'b1,
             1'b0, 1'b0);
      end
    end
    for (int j = 1; j <= IL; j++) begin
      last = (j == IL) || (j == idom);
      step(j != idom, rnd_err(), 1'($urandom), 1'b1, 1'b1, !last,
           !last, 1'b0, last);
      if (last) break;
    end
    idle(2);
  endtask

  initial begin
    logic [5:0] en;
    // reset held with every detector flagging
    step(1'b1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    run_frame(6'b111101, 1'b0, 0, 0, 0);
    run_frame(6'b011110, 1'b0, 0, 0, 0);
    run_frame(6'b101111, 1'b1, 16, 0, 0);
    run_frame(6'b110111, 1'b0, 0, 4, 0);
    run_frame(6'b111011, 1'b1, 3, 0, 2);

    // reset in the middle of the flag
    m_code = cause(6'b111101);
    step(1'b1, 6'b111101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h3f, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h3f, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    m_code = 3'd0;
    step(1'b0, 6'h3f, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    for (int t = 0; t < 60; t++) begin
      en = 6'($urandom);
      if (&en) en[$urandom_range(0, 5)] = 1'b0;
      run_frame(en, 1'($urandom), $urandom_range(0, 20),
                ($urandom_range(0, 2) == 0) ? $urandom_range(2, DL) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, IL) : 0);
      idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
